// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the two-port memory arbiter.
// Owner tags identify which requester a returning read belongs to.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LS   = 2'd2
   } owner_e;

   localparam int AW_DEF         = 16;
   localparam int DW_DEF         = 16;
   localparam int RD_LAT_DEF     = 1;
   localparam int MAX_LS_RUN_DEF = 4;
   localparam int RUN_CNT_W      = 4;

   // Owner of the read issued this cycle; simultaneous rd+wr on load/store is a write.
   function automatic owner_e read_owner(input logic if_gnt, input logic ls_gnt,
                                         input logic ls_rd, input logic ls_wr);
      owner_e own;
      own = OWN_NONE;
      if (if_gnt)
         own = OWN_IF;
      else if (ls_gnt && ls_rd && !ls_wr)
         own = OWN_LS;
      return own;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and shared memory command bus.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          i_if_rd;
   logic [AW-1:0] i_if_addr;
   logic          o_if_waitreq;
   logic          o_if_rdvalid;
   logic [DW-1:0] o_if_rddata;

   logic          i_ls_rd;
   logic          i_ls_wr;
   logic [AW-1:0] i_ls_addr;
   logic [DW-1:0] i_ls_wrdata;
   logic          o_ls_waitreq;
   logic          o_ls_rdvalid;
   logic [DW-1:0] o_ls_rddata;

   logic [AW-1:0] o_mem_addr;
   logic          o_mem_rd;
   logic          o_mem_wr;
   logic [DW-1:0] o_mem_wrdata;
   logic [DW-1:0] i_mem_rddata;

   modport slave (
      input  i_if_rd, i_if_addr,
      output o_if_waitreq, o_if_rdvalid, o_if_rddata,
      input  i_ls_rd, i_ls_wr, i_ls_addr, i_ls_wrdata,
      output o_ls_waitreq, o_ls_rdvalid, o_ls_rddata,
      output o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata,
      input  i_mem_rddata
   );

   modport master (
      output i_if_rd, i_if_addr,
      input  o_if_waitreq, o_if_rdvalid, o_if_rddata,
      output i_ls_rd, i_ls_wr, i_ls_addr, i_ls_wrdata,
      input  o_ls_waitreq, o_ls_rdvalid, o_ls_rddata,
      input  o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata,
      output i_mem_rddata
   );

endinterface

// File: rtl/rd_tag_pipe.sv
// Delay line carrying the owner of each issued read until its data returns
// from memory RD_LAT cycles later.
import mem_arb_pkg::*;

module rd_tag_pipe #(
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic   clk,
   input  logic   reset,
   input  owner_e tag_in,
   output owner_e tag_out
);

   owner_e tag_p [RD_LAT];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++)
            tag_p[i] <= OWN_NONE;
      end else begin
         tag_p[0] <= tag_in;
         for (int i = 1; i < RD_LAT; i++)
            tag_p[i] <= tag_p[i-1];
      end
   end

   assign tag_out = tag_p[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory: load/store has priority,
// with a bounded run length so a waiting fetch is never starved.
import mem_arb_pkg::*;

module mem_arbiter #(
   parameter int AW         = AW_DEF,
   parameter int DW         = DW_DEF,
   parameter int RD_LAT     = RD_LAT_DEF,
   parameter int MAX_LS_RUN = MAX_LS_RUN_DEF
) (
   input  logic           clk,
   input  logic           reset,
   mem_arbiter_if.slave   bus
);

   logic                 ls_req;
   logic                 fetch_prio;
   logic                 ls_gnt;
   logic                 if_gnt;
   logic [RUN_CNT_W-1:0] run_cnt;
   owner_e               tag_push;
   owner_e               tag_pop;

   // Grant is resolved combinationally; nothing is granted while reset is high.
   always_comb begin
      ls_req     = bus.i_ls_rd | bus.i_ls_wr;
      fetch_prio = bus.i_if_rd && (run_cnt == RUN_CNT_W'(MAX_LS_RUN));
      ls_gnt     = !reset && ls_req && !fetch_prio;
      if_gnt     = !reset && bus.i_if_rd && !ls_gnt;
   end

   always_comb begin
      bus.o_mem_addr   = '0;
      bus.o_mem_rd     = 1'b0;
      bus.o_mem_wr     = 1'b0;
      bus.o_mem_wrdata = '0;
      if (ls_gnt) begin
         bus.o_mem_addr   = bus.i_ls_addr;
         bus.o_mem_wr     = bus.i_ls_wr;
         bus.o_mem_rd     = bus.i_ls_rd && !bus.i_ls_wr;
         bus.o_mem_wrdata = bus.i_ls_wrdata;
      end else if (if_gnt) begin
         bus.o_mem_addr = bus.i_if_addr;
         bus.o_mem_rd   = 1'b1;
      end
   end

   assign bus.o_if_waitreq = reset || (bus.i_if_rd && !if_gnt);
   assign bus.o_ls_waitreq = reset || (ls_req && !ls_gnt);

   always_ff @(posedge clk) begin
      if (reset)
         run_cnt <= '0;
      else if (!bus.i_if_rd || if_gnt)
         run_cnt <= '0;
      else if (ls_gnt && run_cnt != RUN_CNT_W'(MAX_LS_RUN))
         run_cnt <= run_cnt + 1'b1;
   end

   // Issue stage -> return stage: owner tags follow reads through the memory latency.
   assign tag_push = read_owner(if_gnt, ls_gnt, bus.i_ls_rd, bus.i_ls_wr);

   rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
      .clk     (clk),
      .reset   (reset),
      .tag_in  (tag_push),
      .tag_out (tag_pop)
   );

   assign bus.o_if_rdvalid = !reset && (tag_pop == OWN_IF);
   assign bus.o_ls_rdvalid = !reset && (tag_pop == OWN_LS);
   assign bus.o_if_rddata  = bus.i_mem_rddata;
   assign bus.o_ls_rddata  = bus.i_mem_rddata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiters (RD_LAT 1, 2, 3) share one stimulus stream,
// each with its own latency-matched memory model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_rd, ls_rd, ls_wr;
   logic [15:0] if_addr, ls_addr, ls_wrdata;
   int          n_total = 0;
   int          n_bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.AW(16), .DW(16)) b1 ();
   mem_arbiter_if #(.AW(16), .DW(16)) b2 ();
   mem_arbiter_if #(.AW(16), .DW(16)) b3 ();

   assign b1.i_if_rd = if_rd;  assign b1.i_if_addr = if_addr;
   assign b1.i_ls_rd = ls_rd;  assign b1.i_ls_wr = ls_wr;
   assign b1.i_ls_addr = ls_addr;  assign b1.i_ls_wrdata = ls_wrdata;
   assign b2.i_if_rd = if_rd;  assign b2.i_if_addr = if_addr;
   assign b2.i_ls_rd = ls_rd;  assign b2.i_ls_wr = ls_wr;
   assign b2.i_ls_addr = ls_addr;  assign b2.i_ls_wrdata = ls_wrdata;
   assign b3.i_if_rd = if_rd;  assign b3.i_if_addr = if_addr;
   assign b3.i_ls_rd = ls_rd;  assign b3.i_ls_wr = ls_wr;
   assign b3.i_ls_addr = ls_addr;  assign b3.i_ls_wrdata = ls_wrdata;

   mem_arbiter #(.AW(16), .DW(16), .RD_LAT(1), .MAX_LS_RUN(4)) u1 (.clk(clk), .reset(reset), .bus(b1));
   mem_arbiter #(.AW(16), .DW(16), .RD_LAT(2), .MAX_LS_RUN(4)) u2 (.clk(clk), .reset(reset), .bus(b2));
   mem_arbiter #(.AW(16), .DW(16), .RD_LAT(3), .MAX_LS_RUN(4)) u3 (.clk(clk), .reset(reset), .bus(b3));

   function automatic logic [15:0] mem_f(input logic [15:0] a);
      return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A00);
   endfunction

   logic [15:0] m1;
   logic [15:0] m2 [2];
   logic [15:0] m3 [3];

   always_ff @(posedge clk) begin
      m1    <= mem_f(b1.o_mem_addr);
      m2[0] <= mem_f(b2.o_mem_addr);
      m2[1] <= m2[0];
      m3[0] <= mem_f(b3.o_mem_addr);
      m3[1] <= m3[0];
      m3[2] <= m3[1];
   end

   assign b1.i_mem_rddata = m1;
   assign b2.i_mem_rddata = m2[1];
   assign b3.i_mem_rddata = m3[2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      if_rd = 1'b0; if_addr = '0;
      ls_rd = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_wrdata = '0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         next_cyc();
         drive_idle();
      end
   endtask

   initial begin
      reset = 1'b1;
      if_rd = 1'b1; if_addr = 16'h0033;
      ls_rd = 1'b0; ls_wr = 1'b1; ls_addr = 16'h0044; ls_wrdata = 16'h7777;
      next_cyc(); next_cyc(); #4;
      check("rst_mem_rd", b1.o_mem_rd, 0);
      check("rst_mem_wr", b1.o_mem_wr, 0);
      check("rst_mem_addr", b1.o_mem_addr, 0);
      check("rst_mem_wrdata", b1.o_mem_wrdata, 0);
      check("rst_if_wait", b1.o_if_waitreq, 1);
      check("rst_ls_wait", b1.o_ls_waitreq, 1);
      check("rst_if_vld", b1.o_if_rdvalid, 0);
      check("rst_ls_vld", b1.o_ls_rdvalid, 0);

      next_cyc(); reset = 1'b0; drive_idle(); #4;
      check("idle_if_wait", b1.o_if_waitreq, 0);
      check("idle_ls_wait", b1.o_ls_waitreq, 0);

      // fetch-only read returning 0xBEEF
      next_cyc(); if_rd = 1'b1; if_addr = 16'h0010; #4;
      check("t033_if_wait", b1.o_if_waitreq, 0);
      check("t033_mem_rd", b1.o_mem_rd, 1);
      check("t033_mem_addr", b1.o_mem_addr, 16'h0010);
      next_cyc(); drive_idle(); #4;
      check("t033_if_vld", b1.o_if_rdvalid, 1);
      check("t033_if_data", b1.o_if_rddata, 16'hBEEF);
      check("t033_ls_vld", b1.o_ls_rdvalid, 0);
      next_cyc(); #4;
      check("t033_if_vld_end", b1.o_if_rdvalid, 0);

      // simultaneous fetch read and load/store write
      next_cyc();
      if_rd = 1'b1; if_addr = 16'h0020;
      ls_wr = 1'b1; ls_addr = 16'h0100; ls_wrdata = 16'h1234; #4;
      check("t034_mem_wr", b1.o_mem_wr, 1);
      check("t034_mem_rd", b1.o_mem_rd, 0);
      check("t034_mem_addr", b1.o_mem_addr, 16'h0100);
      check("t034_mem_wrdata", b1.o_mem_wrdata, 16'h1234);
      check("t034_if_wait", b1.o_if_waitreq, 1);
      check("t034_ls_wait", b1.o_ls_waitreq, 0);
      next_cyc(); ls_wr = 1'b0; ls_addr = '0; ls_wrdata = '0; #4;
      check("t034_if_wait2", b1.o_if_waitreq, 0);
      check("t034_mem_rd2", b1.o_mem_rd, 1);
      check("t034_mem_addr2", b1.o_mem_addr, 16'h0020);
      next_cyc(); drive_idle(); #4;
      check("t034_if_vld", b1.o_if_rdvalid, 1);
      check("t034_if_data", b1.o_if_rddata, 16'h5A20);
      check("t034_ls_vld", b1.o_ls_rdvalid, 0);

      // continuous ls reads with fetch pending: LLLLF repeating
      next_cyc();
      if_rd = 1'b1; if_addr = 16'h0030;
      ls_rd = 1'b1; ls_addr = 16'h0200;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) next_cyc();
         #4;
         check("t035_mem_addr", b1.o_mem_addr, (i % 5 == 4) ? 16'h0030 : 16'h0200);
         check("t035_if_wait", b1.o_if_waitreq, (i % 5 == 4) ? 1'b0 : 1'b1);
         check("t035_ls_wait", b1.o_ls_waitreq, (i % 5 == 4) ? 1'b1 : 1'b0);
      end
      idle(4);

      // rd+wr together is a write with no read response
      next_cyc();
      ls_rd = 1'b1; ls_wr = 1'b1; ls_addr = 16'h0040; ls_wrdata = 16'h5555; #4;
      check("t038_mem_wr", b1.o_mem_wr, 1);
      check("t038_mem_rd", b1.o_mem_rd, 0);
      check("t038_mem_addr", b1.o_mem_addr, 16'h0040);
      check("t038_mem_wrdata", b1.o_mem_wrdata, 16'h5555);
      next_cyc(); drive_idle(); #4;
      check("t038_ls_vld", b1.o_ls_rdvalid, 0);
      check("t038_ls_vld_u3", b3.o_ls_rdvalid, 0);
      idle(4);

      // RD_LAT=3: alternating IF/LS reads back to back
      for (int i = 0; i < 10; i++) begin
         int  j;
         logic exp_if, exp_ls;
         next_cyc();
         drive_idle();
         if (i < 6) begin
            if (i % 2 == 0) begin if_rd = 1'b1; if_addr = 16'(i); end
            else begin ls_rd = 1'b1; ls_addr = 16'(i); end
         end
         #4;
         j = i - 3;
         exp_if = (j >= 0) && (j < 6) && (j % 2 == 0);
         exp_ls = (j >= 0) && (j < 6) && (j % 2 == 1);
         check("t036_mem_rd", b3.o_mem_rd, (i < 6) ? 1'b1 : 1'b0);
         check("t036_if_vld", b3.o_if_rdvalid, exp_if);
         check("t036_ls_vld", b3.o_ls_rdvalid, exp_ls);
         if (exp_if) check("t036_if_data", b3.o_if_rddata, mem_f(16'(j)));
         if (exp_ls) check("t036_ls_data", b3.o_ls_rddata, mem_f(16'(j)));
      end
      idle(4);

      // RD_LAT=2: reset while two reads are in flight
      next_cyc(); if_rd = 1'b1; if_addr = 16'h0050; #4;
      check("t037_if_acc", b2.o_if_waitreq, 0);
      next_cyc(); drive_idle(); ls_rd = 1'b1; ls_addr = 16'h0051; #4;
      check("t037_ls_acc", b2.o_ls_waitreq, 0);
      next_cyc(); drive_idle(); reset = 1'b1; #4;
      check("t037_rst_if_vld", b2.o_if_rdvalid, 0);
      check("t037_rst_ls_vld", b2.o_ls_rdvalid, 0);
      check("t037_rst_if_wait", b2.o_if_waitreq, 1);
      check("t037_rst_ls_wait", b2.o_ls_waitreq, 1);
      check("t037_rst_mem_rd", b2.o_mem_rd, 0);
      next_cyc(); reset = 1'b0; if_rd = 1'b1; if_addr = 16'h0060; #4;
      check("t037_post_if_wait", b2.o_if_waitreq, 0);
      check("t037_post_mem_rd", b2.o_mem_rd, 1);
      check("t037_post_if_vld", b2.o_if_rdvalid, 0);
      check("t037_post_ls_vld", b2.o_ls_rdvalid, 0);
      next_cyc(); drive_idle(); #4;
      check("t037_gap_if_vld", b2.o_if_rdvalid, 0);
      check("t037_gap_ls_vld", b2.o_ls_rdvalid, 0);
      next_cyc(); #4;
      check("t037_new_if_vld", b2.o_if_rdvalid, 1);
      check("t037_new_if_data", b2.o_if_rddata, 16'h5A60);
      check("t037_new_ls_vld", b2.o_ls_rdvalid, 0);

      idle(2);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
